// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 controller-sequencer: T1..T6 ring counter and control-word decoder
module controller_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int T_STATES     = 6
) (
  input  logic                    CLK_n,
  input  logic                    CLR,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [11:0]             con,
  output logic [T_STATES-1:0]     t_state,
  output logic                    halted
);

  typedef enum logic [T_STATES-1:0] {
    T1 = T_STATES'(1),
    T2 = T_STATES'(2),
    T3 = T_STATES'(4),
    T4 = T_STATES'(8),
    T5 = T_STATES'(16),
    T6 = T_STATES'(32)
  } t_state_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'b0000);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'b0001);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'b0010);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'b1110);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'b1111);

  // Control words, bit order Cp Ep Lm_n CE_n | Li_n Ei_n La_n Ea | Su Eu Lb_n Lo_n
  localparam logic [11:0] CON_IDLE   = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_IR_MAR = 12'h1A3;
  localparam logic [11:0] CON_RAM_A  = 12'h2C3;
  localparam logic [11:0] CON_RAM_B  = 12'h2E1;
  localparam logic [11:0] CON_ADD    = 12'h3C7;
  localparam logic [11:0] CON_SUB    = 12'h3CF;
  localparam logic [11:0] CON_OUT    = 12'h3F2;

  t_state_e r_state, w_next_state;
  logic     r_halted, w_next_halted;
  logic [11:0] w_con;

  // Same falling edge as the program counter, so Cp/Ep line up with its update
  always_ff @(negedge CLK_n) begin
    r_state  <= w_next_state;
    r_halted <= w_next_halted;
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_halted = r_halted;
    if (CLR) begin
      w_next_state  = T1;
      w_next_halted = 1'b0;
    end else if (!r_halted) begin
      case (r_state)
        T1: w_next_state = T2;
        T2: w_next_state = T3;
        T3: w_next_state = T4;
        T4: begin
          if (opcode == OP_HLT) w_next_halted = 1'b1;
          else                  w_next_state  = T5;
        end
        T5: w_next_state = T6;
        T6: w_next_state = T1;
        default: w_next_state = T1;
      endcase
    end
  end

  always_comb begin
    w_con = CON_IDLE;
    if (!CLR && !r_halted) begin
      case (r_state)
        T1: w_con = CON_T1;
        T2: w_con = CON_T2;
        T3: w_con = CON_T3;
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) w_con = CON_IR_MAR;
          else if (opcode == OP_OUT)                                    w_con = CON_OUT;
        end
        T5: begin
          if (opcode == OP_LDA)                         w_con = CON_RAM_A;
          else if (opcode == OP_ADD || opcode == OP_SUB) w_con = CON_RAM_B;
        end
        T6: begin
          if (opcode == OP_ADD)      w_con = CON_ADD;
          else if (opcode == OP_SUB) w_con = CON_SUB;
        end
        default: w_con = CON_IDLE;
      endcase
    end
  end

  assign con     = w_con;
  assign t_state = r_state;
  assign halted  = r_halted;

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - scoreboard bench for controller_sequencer
module tb_controller_sequencer;

  logic        CLK_n;
  logic        CLR;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [11:0] con;
    logic [5:0]  ts;
    logic        h;
  } exp_t;

  exp_t sb[$];

  controller_sequencer #(.OPCODE_WIDTH(4), .T_STATES(6)) dut (
    .CLK_n  (CLK_n),
    .CLR    (CLR),
    .opcode (opcode),
    .con    (con),
    .t_state(t_state),
    .halted (halted)
  );

  initial CLK_n = 1'b1;
  always #5 CLK_n = ~CLK_n;

  // Monitor: state changes on negedge, so compare on the rising edge
  always @(posedge CLK_n) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (con !== e.con) begin
        errors++;
        $display("FAIL %s con actual=%h required=%h", e.name, con, e.con);
      end
      checks++;
      if (t_state !== e.ts) begin
        errors++;
        $display("FAIL %s t_state actual=%h required=%h", e.name, t_state, e.ts);
      end
      checks++;
      if (halted !== e.h) begin
        errors++;
        $display("FAIL %s halted actual=%b required=%b", e.name, halted, e.h);
      end
    end
  end

  task automatic cyc(input string name, input logic clr, input logic [3:0] op,
                     input logic [11:0] econ, input logic [5:0] ets, input logic eh);
    exp_t e;
    @(negedge CLK_n);
    #1;
    CLR    = clr;
    opcode = op;
    e.name = name; e.con = econ; e.ts = ets; e.h = eh;
    sb.push_back(e);
  endtask

  task automatic fetch(input string name, input logic [3:0] op);
    cyc({name, "_t1"}, 1'b0, op, 12'h5E3, 6'h01, 1'b0);
    cyc({name, "_t2"}, 1'b0, op, 12'hBE3, 6'h02, 1'b0);
    cyc({name, "_t3"}, 1'b0, op, 12'h263, 6'h04, 1'b0);
  endtask

  initial begin
    CLR    = 1'b1;
    opcode = 4'h0;
    repeat (2) @(negedge CLK_n);

    cyc("reset_hold", 1'b1, 4'h0, 12'h3E3, 6'h01, 1'b0);

    fetch("lda", 4'h0);
    cyc("lda_t4", 1'b0, 4'h0, 12'h1A3, 6'h08, 1'b0);
    cyc("lda_t5", 1'b0, 4'h0, 12'h2C3, 6'h10, 1'b0);
    cyc("lda_t6", 1'b0, 4'h0, 12'h3E3, 6'h20, 1'b0);

    fetch("add", 4'h1);
    cyc("add_t4", 1'b0, 4'h1, 12'h1A3, 6'h08, 1'b0);
    cyc("add_t5", 1'b0, 4'h1, 12'h2E1, 6'h10, 1'b0);
    cyc("add_t6", 1'b0, 4'h1, 12'h3C7, 6'h20, 1'b0);

    fetch("sub", 4'h2);
    cyc("sub_t4", 1'b0, 4'h2, 12'h1A3, 6'h08, 1'b0);
    cyc("sub_t5", 1'b0, 4'h2, 12'h2E1, 6'h10, 1'b0);
    cyc("sub_t6", 1'b0, 4'h2, 12'h3CF, 6'h20, 1'b0);

    fetch("out", 4'hE);
    cyc("out_t4", 1'b0, 4'hE, 12'h3F2, 6'h08, 1'b0);
    cyc("out_t5", 1'b0, 4'hE, 12'h3E3, 6'h10, 1'b0);
    cyc("out_t6", 1'b0, 4'hE, 12'h3E3, 6'h20, 1'b0);

    // HLT opcode during fetch must be ignored
    fetch("nop_fetch_hlt_op", 4'hF);
    cyc("nop_t4", 1'b0, 4'h5, 12'h3E3, 6'h08, 1'b0);
    cyc("nop_t5", 1'b0, 4'h5, 12'h3E3, 6'h10, 1'b0);
    cyc("nop_t6", 1'b0, 4'h5, 12'h3E3, 6'h20, 1'b0);

    // Opcode changed mid-execute is reflected combinationally
    fetch("live_op", 4'h0);
    cyc("live_t4_out", 1'b0, 4'hE, 12'h3F2, 6'h08, 1'b0);
    cyc("live_t5_lda", 1'b0, 4'h0, 12'h2C3, 6'h10, 1'b0);
    cyc("live_t6_sub", 1'b0, 4'h2, 12'h3CF, 6'h20, 1'b0);

    fetch("abort", 4'h1);
    cyc("abort_t4", 1'b0, 4'h1, 12'h1A3, 6'h08, 1'b0);
    cyc("abort_clr", 1'b1, 4'h1, 12'h3E3, 6'h10, 1'b0);

    fetch("hlt", 4'hF);
    cyc("hlt_t4", 1'b0, 4'hF, 12'h3E3, 6'h08, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc("halted_hold", 1'b0, (i % 2 == 0) ? 4'h1 : 4'hF, 12'h3E3, 6'h08, 1'b1);

    cyc("halt_clr", 1'b1, 4'hF, 12'h3E3, 6'h08, 1'b1);
    fetch("recover", 4'h0);
    cyc("recover_t4", 1'b0, 4'h0, 12'h1A3, 6'h08, 1'b0);
    cyc("recover_t5", 1'b0, 4'h0, 12'h2C3, 6'h10, 1'b0);
    cyc("recover_t6", 1'b0, 4'h0, 12'h3E3, 6'h20, 1'b0);
    cyc("recover_wrap", 1'b0, 4'h0, 12'h5E3, 6'h01, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge CLK_n);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
